// File: rtl/ks_pipe_sum.sv
// ks_pipe_sum: flow-controlled Kogge-Stone adder, one registered prefix level per stage.
// Optional macro KS_SUB_EN enables in_sub (a - b with no-borrow carry-out).
module ks_pipe_sum #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout
);
   localparam int LEVELS = $clog2(WIDTH);
   localparam int NS     = LEVELS + 2;

   logic [WIDTH-1:0] b_eff;
   logic             c_eff;
   logic [WIDTH:0]   g0_d;
   logic [WIDTH:0]   p0_d;

   // Index 0 of each prefix vector is the carry-in position.
   logic [WIDTH:0]   g_q  [0:LEVELS];
   logic [WIDTH:0]   p_q  [0:LEVELS-1];
   logic [WIDTH:1]   pb_q [0:LEVELS];
   logic [LEVELS:0]  gt_q;
   logic [WIDTH:0]   g_d  [1:LEVELS];
   logic [WIDTH:0]   p_d  [1:LEVELS-1];

   logic [NS-1:0]    v_q;
   logic [NS-1:0]    v_src;
   logic [NS-1:0]    ld;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             unused_ok;

`ifdef KS_SUB_EN
   assign b_eff     = in_sub ? ~in_b : in_b;
   assign c_eff     = in_sub | in_cin;
   assign unused_ok = g_q[LEVELS][WIDTH];
`else
   assign b_eff     = in_b;
   assign c_eff     = in_cin;
   assign unused_ok = ^{in_sub, g_q[LEVELS][WIDTH]};
`endif

   assign g0_d  = {in_a & b_eff, c_eff};
   assign p0_d  = {in_a ^ b_eff, 1'b0};
   assign v_src = {v_q[NS-2:0], in_valid};

   genvar gi, gj;
   generate
      for (gi = 1; gi <= LEVELS; gi++) begin : g_lvl
         localparam int D = 1 << (gi - 1);
         for (gj = 0; gj <= WIDTH; gj++) begin : g_bit
            if (gj >= D) begin : g_comb
               assign g_d[gi][gj] = g_q[gi-1][gj] | (p_q[gi-1][gj] & g_q[gi-1][gj-D]);
            end else begin : g_pass
               assign g_d[gi][gj] = g_q[gi-1][gj];
            end
            // Group propagate is not needed past the last prefix level.
            if (gi < LEVELS) begin : g_prop
               if (gj >= D) begin : g_pcomb
                  assign p_d[gi][gj] = p_q[gi-1][gj] & p_q[gi-1][gj-D];
               end else begin : g_ppass
                  assign p_d[gi][gj] = p_q[gi-1][gj];
               end
            end
         end
      end
   endgenerate

   // A stage loads when it is empty or its contents move on downstream.
   always_comb begin
      logic chain;
      ld    = '0;
      chain = out_ready;
      for (int k = NS - 1; k >= 0; k--) begin
         chain = ~v_q[k] | chain;
         ld[k] = chain;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v_q    <= '0;
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else begin
         for (int k = 0; k < NS; k++) begin
            if (ld[k]) v_q[k] <= v_src[k];
         end
         if (ld[NS-1] && v_q[NS-2]) begin
            sum_q  <= pb_q[LEVELS][WIDTH:1] ^ g_q[LEVELS][WIDTH-1:0];
            cout_q <= gt_q[LEVELS] | (pb_q[LEVELS][WIDTH] & g_q[LEVELS][WIDTH-1]);
         end
      end
      if (ld[0]) begin
         g_q[0]  <= g0_d;
         p_q[0]  <= p0_d;
         pb_q[0] <= p0_d[WIDTH:1];
         gt_q[0] <= g0_d[WIDTH];
      end
      for (int k = 1; k <= LEVELS; k++) begin
         if (ld[k]) begin
            g_q[k]  <= g_d[k];
            pb_q[k] <= pb_q[k-1];
            gt_q[k] <= gt_q[k-1];
         end
      end
      for (int k = 1; k < LEVELS; k++) begin
         if (ld[k]) p_q[k] <= p_d[k];
      end
   end

   assign in_ready  = ld[0];
   assign out_valid = v_q[NS-1];
   assign out_sum   = sum_q;
   assign out_cout  = cout_q;
endmodule
